serial_adder: RTL and testbench

- Bit-serial N-bit adder that wraps a single full-adder bit cell with a carry flip-flop, operand shift registers and a control FSM.
- Consumes two N-bit operands on a start handshake and processes one bit per clock, LSB first.
- Returns an N-bit sum plus carry-out with a one-cycle done pulse.
- Sits directly downstream of the combinational full-adder cell and turns it into the team's first clocked arithmetic stage.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/sa_bit_cell.sv | 13 +
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional subtract mode is selected with the SERIAL_ADDER_SUB_EN macro in serial_adder.sv.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold values 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sa_bit_cell.sv
// Combinational 1-bit full adder used as the datapath of serial_adder.
module sa_bit_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = x_i ^ y_i ^ c_i;
    assign co_o = (x_i & y_i) | (x_i & c_i) | (y_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus carry flop, LSB-first, done pulse at the end.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns the operation into a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;

    logic [N-1:0]  b_load;
    logic          carry_init;
    logic          cell_s;
    logic          cell_co;

    // Subtraction is a + ~b + 1: B is inverted once at capture, so the
    // cell always sees the operand bit it must add.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    sa_bit_cell u_cell (
        .x_i  (a_q[0]),
        .y_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (cell_s),
        .co_o (cell_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                sum_d        = sum_q >> 1;
                sum_d[N-1]   = cell_s;
                carry_d      = cell_co;
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = cell_co;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset clears the datapath as well so an aborted operation leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=4): directed cases plus randomized operands vs an arithmetic model.
module tb_serial_adder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {carry/no-borrow, N-bit result}.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        int unsigned xi, yi, r;
        xi = x;
        yi = y;
        if (s) begin
            r = (xi + (1 << N) - yi) % (1 << N);
            return {(xi >= yi), r[N-1:0]};
        end
        r = xi + yi;
        return r[N:0];
    endfunction

    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                         input bit hold, input string tag);
        logic [N:0] exp;
        int lat;
        int busy_cnt;
        exp = model(x, y, s);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = s;
`endif
        @(posedge clk);
        #1;
        check({tag, " busy after accept"}, busy, 1);
        check({tag, " sum cleared"}, sum, 0);
        @(negedge clk);
        start = hold;
        a     = hold ? N'(2) : N'($urandom);
        b     = hold ? N'(2) : N'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'($urandom);
`endif
        lat      = -1;
        busy_cnt = 1;
        for (int i = 1; i <= N + 3; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, N);
        check({tag, " busy cycles"}, busy_cnt, N + 1);
        check({tag, " sum"}, sum, exp[N-1:0]);
        check({tag, " cout"}, cout, exp[N]);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " sum held"}, {cout, sum}, exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit saw_done;
        logic [N-1:0] ra, rb;
        logic rs;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 4'hF;
        b     = 4'hF;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        // Reset hold with start asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset sum", sum, 0);
            check("reset cout", cout, 0);
            check("reset busy", busy, 0);
            check("reset done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;

        do_op(4'd5, 4'd3, 1'b0, 1'b0, "add 5+3");
        do_op(4'hF, 4'h1, 1'b0, 1'b0, "add F+1");
        do_op(4'hF, 4'hF, 1'b0, 1'b0, "add F+F");

        // Start held through the op: only the 1+1 request is taken
        do_op(4'd1, 4'd1, 1'b0, 1'b1, "held start");
        @(posedge clk);
        #1;
        check("held start no new op", busy, 0);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 0);
        do_op(4'd1, 4'd1, 1'b0, 1'b0, "after abort 1+1");

`ifdef SERIAL_ADDER_SUB_EN
        do_op(4'd5, 4'd3, 1'b1, 1'b0, "sub 5-3");
        do_op(4'd3, 4'd5, 1'b1, 1'b0, "sub 3-5");
        do_op(4'd5, 4'd3, 1'b0, 1'b0, "sub0 5+3");
`endif

        for (int k = 0; k < 20; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            do_op(ra, rb, rs, 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
